// File: rtl/wb_coherent_arbiter.sv
// Round-robin Wishbone arbiter sharing one memory slave between NUM_CORES masters,
// with owner-locked cycles and a slave watchdog. Define WB_ARB_SNOOP_EN for write snooping.
module wb_coherent_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 255,
    localparam int GW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int SW       = DW / 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,

    input  logic [NUM_CORES*AW-1:0] m_adr_i,
    input  logic [NUM_CORES*DW-1:0] m_dat_i,
    input  logic [NUM_CORES*SW-1:0] m_sel_i,
    input  logic [NUM_CORES-1:0]    m_we_i,
    input  logic [NUM_CORES-1:0]    m_cyc_i,
    input  logic [NUM_CORES-1:0]    m_stb_i,
    output logic [DW-1:0]           m_dat_o,
    output logic [NUM_CORES-1:0]    m_ack_o,
    output logic [NUM_CORES-1:0]    m_err_o,
    output logic [NUM_CORES-1:0]    m_rty_o,

    output logic [AW-1:0]           s_adr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [SW-1:0]           s_sel_o,
    output logic                    s_we_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    input  logic [DW-1:0]           s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,

    output logic [GW-1:0]           grant_o,
    output logic                    busy_o,
    output logic                    snoop_valid_o,
    output logic [AW-1:0]           snoop_adr_o,
    output logic [GW-1:0]           snoop_src_o
);

    localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [GW-1:0]  r_grant;
    logic [GW-1:0]  r_last;
    logic [GW-1:0]  w_pick;
    logic [WDW-1:0] r_wdt;

    logic [AW-1:0]  w_adr [NUM_CORES];
    logic [DW-1:0]  w_dat [NUM_CORES];
    logic [SW-1:0]  w_sel [NUM_CORES];

    logic w_anyReq;
    logic w_busy;
    logic w_ownCyc;
    logic w_ownStb;
    logic w_ownWe;
    logic w_stbRaw;
    logic w_resp;
    logic w_timeout;

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_split
        assign w_adr[k] = m_adr_i[k*AW +: AW];
        assign w_dat[k] = m_dat_i[k*DW +: DW];
        assign w_sel[k] = m_sel_i[k*SW +: SW];
    end

    assign w_anyReq = |m_cyc_i;
    assign w_busy   = (r_state == BUSY);
    assign w_ownCyc = m_cyc_i[r_grant];
    assign w_ownStb = m_stb_i[r_grant];
    assign w_ownWe  = m_we_i[r_grant];
    assign w_stbRaw = w_busy & w_ownCyc & w_ownStb;
    assign w_resp   = s_ack_i | s_err_i | s_rty_i;

    // A response arriving on the terminal-count cycle completes normally instead of timing out.
    assign w_timeout = w_stbRaw & ~w_resp & (r_wdt == WDW'(TIMEOUT));

    assign s_adr_o = w_adr[r_grant];
    assign s_dat_o = w_dat[r_grant];
    assign s_sel_o = w_sel[r_grant];
    assign s_we_o  = w_busy & w_ownWe & ~w_timeout;
    assign s_cyc_o = w_busy & w_ownCyc & ~w_timeout;
    assign s_stb_o = w_stbRaw & ~w_timeout;
    assign m_dat_o = s_dat_i;

    assign grant_o = r_grant;
    assign busy_o  = (r_state != IDLE);

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (w_busy) begin
            m_ack_o[r_grant] = s_ack_i & w_ownCyc;
            m_err_o[r_grant] = (s_err_i & w_ownCyc) | w_timeout;
            m_rty_o[r_grant] = s_rty_i & w_ownCyc;
        end
    end

    // Search upward from the master after the previous owner, wrapping at NUM_CORES.
    always_comb begin
        int            idx;
        logic [GW-1:0] cand;
        logic          found;
        idx    = 0;
        cand   = '0;
        found  = 1'b0;
        w_pick = r_last;
        for (int i = 1; i <= NUM_CORES; i++) begin
            idx  = (int'(r_last) + i) % NUM_CORES;
            cand = idx[GW-1:0];
            if (!found && m_cyc_i[cand]) begin
                w_pick = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_stateNext = BUSY;
                end
            end
            BUSY: begin
                if (!w_ownCyc) begin
                    w_stateNext = IDLE;
                end else if (w_timeout) begin
                    w_stateNext = ABORT;
                end
            end
            ABORT: begin
                if (!w_ownCyc) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_CORES - 1);
            r_wdt   <= '0;
        end else begin
            r_state <= w_stateNext;
            if ((r_state == IDLE) && w_anyReq) begin
                r_grant <= w_pick;
            end
            if ((r_state != IDLE) && !w_ownCyc) begin
                r_last <= r_grant;
            end
            if (w_stbRaw && !w_resp && !w_timeout) begin
                r_wdt <= r_wdt + WDW'(1);
            end else begin
                r_wdt <= '0;
            end
        end
    end

`ifdef WB_ARB_SNOOP_EN
    logic          r_snoopValid;
    logic [AW-1:0] r_snoopAdr;
    logic [GW-1:0] r_snoopSrc;
    logic          w_snoopHit;

    // Only acked writes are broadcast; err, rty and watchdog aborts never reach here.
    assign w_snoopHit = w_stbRaw & s_ack_i & w_ownWe;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_snoopValid <= 1'b0;
            r_snoopAdr   <= '0;
            r_snoopSrc   <= '0;
        end else begin
            r_snoopValid <= w_snoopHit;
            if (w_snoopHit) begin
                r_snoopAdr <= s_adr_o;
                r_snoopSrc <= r_grant;
            end
        end
    end

    assign snoop_valid_o = r_snoopValid;
    assign snoop_adr_o   = r_snoopAdr;
    assign snoop_src_o   = r_snoopSrc;
`else
    assign snoop_valid_o = 1'b0;
    assign snoop_adr_o   = '0;
    assign snoop_src_o   = '0;
`endif

endmodule
